rsa_result_serializer: RTL and testbench

- Consumer side of the RSA result stream.
- Accepts each 256-bit o_crypto result from the RSA top over its valid/ready handshake and emits it as a stream of 32-bit words toward the host interface.
- A two-entry result buffer lets the RSA core hand off the next result while the previous one is still being serialized.
- Sits between the RSA top output port and the host read-back path.

---
 rtl/rsa_result_serializer.sv | 105 ++++++++++
 tb/tb_rsa_result_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_result_serializer.sv
// rtl/rsa_result_serializer.sv - two-entry RSA result buffer serialized into WORD_W-bit words
// Optional trailing XOR checksum word per result when RSA_SER_CHECKSUM_EN is defined.
module rsa_result_serializer #(
    parameter int KEY_W  = 256,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [KEY_W-1:0]  i_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last,
    output logic              o_busy
);
    localparam int NWORD = KEY_W / WORD_W;
`ifdef RSA_SER_CHECKSUM_EN
    localparam int LAST_IDX = NWORD;
`else
    localparam int LAST_IDX = NWORD - 1;
`endif
    localparam int IDX_W = (LAST_IDX > 0) ? $clog2(LAST_IDX + 1) : 1;

    if (KEY_W % WORD_W != 0) begin : g_width_check
        $fatal(1, "KEY_W must be a multiple of WORD_W");
    end

    logic [KEY_W-1:0]  mem [2];
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data_word;
    logic              push;
    logic              xfer;
    logic              pop;

    // i_ready comes only from registered count (and reset), never from o_ready/i_valid
    assign i_ready = rst && (count != 2'd2);
    assign o_valid = (count != 2'd0);
    assign o_busy  = (count != 2'd0);
    assign o_last  = o_valid && (idx == IDX_W'(LAST_IDX));
    assign push    = i_valid && i_ready;
    assign xfer    = o_valid && o_ready;
    assign pop     = xfer && o_last;

    always_comb begin
        data_word = '0;
        for (int k = 0; k < NWORD; k++) begin
            if (idx == IDX_W'(k)) begin
                data_word = mem[rd_ptr][k*WORD_W +: WORD_W];
            end
        end
    end

`ifdef RSA_SER_CHECKSUM_EN
    logic [WORD_W-1:0] csum;

    always_comb begin
        csum = '0;
        for (int k = 0; k < NWORD; k++) begin
            csum = csum ^ mem[rd_ptr][k*WORD_W +: WORD_W];
        end
    end

    assign o_word = !o_valid ? '0 : ((idx == IDX_W'(NWORD)) ? csum : data_word);
`else
    assign o_word = o_valid ? data_word : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            idx    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (xfer) begin
                if (o_last) begin
                    idx    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry under read is never the write target: at count==1 the pointers differ, at count==2 no push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end
endmodule

// File: tb/tb_rsa_result_serializer.sv
// tb/tb_rsa_result_serializer.sv - randomized scoreboard bench for rsa_result_serializer
// Honours RSA_SER_CHECKSUM_EN to expect the trailing XOR word.
module tb_rsa_result_serializer;
    localparam int KEY_W  = 256;
    localparam int WORD_W = 32;
    localparam int NWORD  = KEY_W / WORD_W;
`ifdef RSA_SER_CHECKSUM_EN
    localparam int LEN = NWORD + 1;
`else
    localparam int LEN = NWORD;
`endif

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready = 1'b0;
    logic [KEY_W-1:0]  i_data  = '0;
    logic              i_ready;
    logic              o_valid;
    logic [WORD_W-1:0] o_word;
    logic              o_last;
    logic              o_busy;

    always #5 clk = ~clk;

    rsa_result_serializer #(.KEY_W(KEY_W), .WORD_W(WORD_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_word  (o_word),
        .o_last  (o_last),
        .o_busy  (o_busy)
    );

    // Expected output stream: {last, word}, front = word currently due
    logic [WORD_W:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int pending();
        return (exp_q.size() + LEN - 1) / LEN;
    endfunction

    function automatic logic [WORD_W+3:0] exp_vec();
        logic              v;
        logic              l;
        logic [WORD_W-1:0] w;
        v = (exp_q.size() != 0);
        l = 1'b0;
        w = '0;
        if (v) begin
            l = exp_q[0][WORD_W];
            w = exp_q[0][WORD_W-1:0];
        end
        return {v, l, v, rst & (pending() < 2), w};
    endfunction

    function automatic logic [WORD_W+3:0] dut_vec();
        return {o_valid, o_last, o_busy, i_ready, (o_valid ? o_word : {WORD_W{1'b0}})};
    endfunction

    function automatic logic [KEY_W-1:0] rand_key();
        logic [KEY_W-1:0] r;
        for (int k = 0; k < NWORD; k++) r[k*WORD_W +: WORD_W] = $urandom;
        return r;
    endfunction

    task automatic drive(input logic r, input logic iv, input logic [KEY_W-1:0] d, input logic ordy);
        @(negedge clk);
        rst     = r;
        i_valid = iv;
        i_data  = d;
        o_ready = ordy;
        #1;
    endtask

    // Advance the reference model across the coming clock edge
    task automatic model_commit(output bit acc);
        bit                xfer;
        bit                take;
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] cs;
        acc = 1'b0;
        if (!rst) begin
            exp_q.delete();
        end else begin
            xfer = o_ready && (exp_q.size() != 0);
            take = i_valid && (pending() < 2);
            if (xfer) void'(exp_q.pop_front());
            if (take) begin
                cs = '0;
                for (int k = 0; k < NWORD; k++) begin
                    w  = i_data[k*WORD_W +: WORD_W];
                    cs = cs ^ w;
                    exp_q.push_back({1'((LEN == NWORD) && (k == NWORD - 1)), w});
                end
`ifdef RSA_SER_CHECKSUM_EN
                exp_q.push_back({1'b1, cs});
`endif
                acc = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, rand_key(), 1'b1);
        repeat (2) begin
            drive(1'b0, 1'b1, rand_key(), 1'b1);
            n_cmp++;
            if ({o_valid, o_last, o_busy, i_ready, o_word} !== {(WORD_W+4){1'b0}}) begin
                n_fail++;
                $display("FAIL reset_state: got v%b l%b b%b r%b w%h want all zero",
                         o_valid, o_last, o_busy, i_ready, o_word);
            end
        end
        exp_q.delete();
        drive(1'b1, 1'b0, '0, 1'b0);
        n_cmp++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got i_ready=%b o_valid=%b want 1 0", i_ready, o_valid);
        end
    endtask

    task automatic test_single();
        logic [KEY_W-1:0] d;
        bit acc;
        for (int k = 0; k < NWORD; k++) d[k*WORD_W +: WORD_W] = {8{4'(k + 1)}};
        drive(1'b1, 1'b1, d, 1'b1);
        for (int c = 0; c < LEN + 4; c++) begin
            if (c > 0) drive(1'b1, 1'b0, '0, 1'b1);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            model_commit(acc);
        end
    endtask

    task automatic test_buffer_full();
        logic [KEY_W-1:0] r [3];
        int sent = 0;
        int cyc  = 0;
        bit acc;
        for (int i = 0; i < 3; i++) r[i] = rand_key();
        while ((sent < 3 || exp_q.size() != 0) && cyc < 200) begin
            drive(1'b1, 1'(sent < 3), r[sent % 3], 1'(cyc >= 4));
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL buffer_full cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
            model_commit(acc);
            if (acc) sent++;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL buffer_full_timeout: got %0d cycles want < 200", cyc);
        end
    endtask

    task automatic test_simul_push_pop();
        logic [KEY_W-1:0] a;
        logic [KEY_W-1:0] b;
        bit b_sent = 1'b0;
        bit acc;
        int cyc = 0;
        a = rand_key();
        b = rand_key();
        drive(1'b1, 1'b1, a, 1'b1);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL push_pop start: got %h want %h", dut_vec(), exp_vec());
        end
        model_commit(acc);
        while (exp_q.size() != 0 && cyc < 60) begin
            // offer B exactly when A's last word is on the bus
            drive(1'b1, 1'(!b_sent && exp_q.size() == 1), b, 1'b1);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL push_pop cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
            model_commit(acc);
            if (acc) b_sent = 1'b1;
            cyc++;
        end
        n_cmp++;
        if (!b_sent || cyc >= 60) begin
            n_fail++;
            $display("FAIL push_pop_done: got b_sent=%0d cyc=%0d want 1 <60", b_sent, cyc);
        end
    endtask

    task automatic test_random_stalls();
        int sent = 0;
        int cyc  = 0;
        bit acc;
        bit iv;
        while ((sent < 20 || exp_q.size() != 0) && cyc < 3000) begin
            iv = (sent < 20) && ($urandom_range(1, 0) == 1);
            drive(1'b1, iv, rand_key(), 1'($urandom_range(2, 0) != 0));
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_stall cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
            model_commit(acc);
            if (acc) sent++;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 3000) begin
            n_fail++;
            $display("FAIL random_stall_timeout: got sent=%0d left=%0d want drained", sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        for (int c = 0; c < 6 + LEN + 4; c++) begin
            case (c)
                0, 1:    drive(1'b1, 1'b1, rand_key(), 1'b1);
                5:       drive(1'b0, 1'b0, '0, 1'b1);
                6:       drive(1'b1, 1'b1, rand_key(), 1'b1);
                default: drive(1'b1, 1'b0, '0, 1'b1);
            endcase
            if (c == 6) begin
                n_cmp++;
                if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_clear: got o_valid=%b o_busy=%b want 0 0", o_valid, o_busy);
                end
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            model_commit(acc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_buffer_full();
        test_simul_push_pop();
        test_random_stalls();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
